tx_scrambler: RTL and testbench

TX_SCRAMBLER -- requirements
Module: tx_scrambler

---
 rtl/tx_scrambler_pkg.sv | 25 ++
 rtl/tx_scrambler_scrambler_core.sv | 33 +++
 rtl/tx_scrambler.sv | 137 +++++++++++++
 tb/tb_tx_scrambler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_scrambler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_scrambler_pkg
// Purpose  : Shared framing constants, scrambler taps and FSM encodings for
//            the lane TX scrambler and its RX descrambler counterpart.
// Revision : 1.0
// ============================================================================
package tx_scrambler_pkg;

  localparam logic [63:0] c_SYNC_WORD_DFLT   = 64'h78f678f678f678f6;
  localparam logic [5:0]  c_STATE_BLOCK_TYPE = 6'b001010;
  localparam logic [1:0]  c_CTRL_HEADER      = 2'b10;
  localparam int          c_SCR_W            = 58;
  localparam int          c_TAP_A            = 38;
  localparam int          c_TAP_B            = 57;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SYNC_WORD  = 2'd1,
    ST_STATE_WORD = 2'd2,
    ST_PAYLOAD    = 2'd3
  } tx_state_e;

endpackage : tx_scrambler_pkg
`default_nettype wire

// File: rtl/tx_scrambler_scrambler_core.sv
`default_nettype none
// ============================================================================
// Module   : scrambler_core
// Purpose  : Combinational 64-bit self-synchronous x^58+x^39+1 scramble,
//            bit 0 first, returning the scrambled word and next state.
// Revision : 1.0
// ============================================================================
module scrambler_core
  import tx_scrambler_pkg::*;
(
  input  logic [63:0]        data_i,
  input  logic [c_SCR_W-1:0] state_i,
  output logic [63:0]        data_o,
  output logic [c_SCR_W-1:0] state_o
);

  logic [63:0]        w_out;
  logic [c_SCR_W-1:0] w_s;

  // Each scrambled bit is shifted back into the state before the next bit.
  always_comb begin
    w_out = '0;
    w_s   = state_i;
    for (int i = 0; i < 64; i++) begin
      w_out[i] = data_i[i] ^ w_s[c_TAP_A] ^ w_s[c_TAP_B];
      w_s      = {w_s[c_SCR_W-2:0], w_out[i]};
    end
    data_o  = w_out;
    state_o = w_s;
  end

endmodule : scrambler_core
`default_nettype wire

// File: rtl/tx_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : tx_scrambler
// Purpose  : Meta-frame TX lane framer (sync word, state word, payload) with
//            64-bit scrambling and raw passthrough mode.
//            Optional macro TX_SYNC_ERR_INJECT_EN adds INJECT_SYNC_ERR.
// Revision : 1.0
// ============================================================================
module tx_scrambler
  import tx_scrambler_pkg::*;
#(
  parameter int                  TX_DATA_WIDTH  = 64,
  parameter logic [63:0]         SYNC_WORD      = c_SYNC_WORD_DFLT,
  parameter int                  META_FRAME_LEN = 16,
  parameter logic [c_SCR_W-1:0]  SCRAMBLER_SEED = {c_SCR_W{1'b1}},
  parameter logic [63:0]         IDLE_WORD      = 64'h0
) (
  input  logic                     USER_CLK,
  input  logic                     SYSTEM_RESET,
  input  logic [TX_DATA_WIDTH-1:0] UNSCRAMBLED_DATA_IN,
  input  logic [1:0]               HEADER_IN,
  input  logic                     DATA_VALID,
  output logic                     DATA_READY,
  input  logic                     PASSTHROUGH,
  output logic [TX_DATA_WIDTH-1:0] SCRAMBLED_DATA_OUT,
  output logic [1:0]               HEADER_OUT,
  output logic                     DATA_VALID_OUT
`ifdef TX_SYNC_ERR_INJECT_EN
  ,
  input  logic                     INJECT_SYNC_ERR
`endif
);

  localparam int                CNT_W      = $clog2(META_FRAME_LEN);
  localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(META_FRAME_LEN - 3);

  tx_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [c_SCR_W-1:0]       scr_q, scr_d;
  logic [TX_DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]               hdr_q, hdr_d;
  logic                     dvo_q, dvo_d;

  logic [63:0]              w_payload;
  logic [63:0]              w_scr_data;
  logic [c_SCR_W-1:0]       w_scr_next;
  logic [63:0]              w_sync_flip;

`ifdef TX_SYNC_ERR_INJECT_EN
  assign w_sync_flip = {63'b0, INJECT_SYNC_ERR};
`else
  assign w_sync_flip = 64'b0;
`endif

  assign w_payload  = DATA_VALID ? UNSCRAMBLED_DATA_IN : IDLE_WORD;
  assign DATA_READY = PASSTHROUGH | ((state_q == ST_PAYLOAD) & ~SYSTEM_RESET);

  scrambler_core u_core (
    .data_i  (w_payload),
    .state_i (scr_q),
    .data_o  (w_scr_data),
    .state_o (w_scr_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scr_d   = scr_q;
    data_d  = data_q;
    hdr_d   = hdr_q;
    dvo_d   = dvo_q;
    if (PASSTHROUGH) begin
      // Raw echo; the frame is abandoned but the scrambler state is kept.
      data_d  = UNSCRAMBLED_DATA_IN;
      hdr_d   = HEADER_IN;
      dvo_d   = DATA_VALID;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          dvo_d   = 1'b0;
          state_d = ST_SYNC_WORD;
        end
        ST_SYNC_WORD: begin
          data_d  = SYNC_WORD ^ w_sync_flip;
          hdr_d   = c_CTRL_HEADER;
          dvo_d   = 1'b1;
          state_d = ST_STATE_WORD;
        end
        ST_STATE_WORD: begin
          data_d  = {c_STATE_BLOCK_TYPE, scr_q};
          hdr_d   = c_CTRL_HEADER;
          dvo_d   = 1'b1;
          state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          data_d = w_scr_data;
          hdr_d  = DATA_VALID ? HEADER_IN : c_CTRL_HEADER;
          dvo_d  = 1'b1;
          scr_d  = w_scr_next;
          if (cnt_q == c_CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_SYNC_WORD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      scr_q   <= SCRAMBLER_SEED;
      data_q  <= '0;
      hdr_q   <= '0;
      dvo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scr_q   <= scr_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      dvo_q   <= dvo_d;
    end
  end

  assign SCRAMBLED_DATA_OUT = data_q;
  assign HEADER_OUT         = hdr_q;
  assign DATA_VALID_OUT     = dvo_q;

endmodule : tx_scrambler
`default_nettype wire

// File: tb/tb_tx_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_scrambler
// Purpose  : Directed self-checking bench for tx_scrambler; payload words are
//            recovered with a bench-side descrambler.
// Revision : 1.0
// ============================================================================
module tb_tx_scrambler;

  localparam logic [63:0] c_SYNC        = 64'h78f678f678f678f6;
  localparam logic [63:0] c_STATE_SEED  = 64'h2BFFFFFFFFFFFFFF;
  localparam logic [63:0] c_FIRST_ZERO  = 64'h03FFFF8000000000;

  logic        USER_CLK;
  logic        SYSTEM_RESET;
  logic [63:0] UNSCRAMBLED_DATA_IN;
  logic [1:0]  HEADER_IN;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic        PASSTHROUGH;
  logic [63:0] SCRAMBLED_DATA_OUT;
  logic [1:0]  HEADER_OUT;
  logic        DATA_VALID_OUT;
`ifdef TX_SYNC_ERR_INJECT_EN
  logic        inj_bit;
`endif

  int          n_checks;
  int          n_errors;
  int          pos;
  logic [57:0] rx_s;
  bit          rx_known;

  tx_scrambler dut (
    .USER_CLK            (USER_CLK),
    .SYSTEM_RESET        (SYSTEM_RESET),
    .UNSCRAMBLED_DATA_IN (UNSCRAMBLED_DATA_IN),
    .HEADER_IN           (HEADER_IN),
    .DATA_VALID          (DATA_VALID),
    .DATA_READY          (DATA_READY),
    .PASSTHROUGH         (PASSTHROUGH),
    .SCRAMBLED_DATA_OUT  (SCRAMBLED_DATA_OUT),
    .HEADER_OUT          (HEADER_OUT),
    .DATA_VALID_OUT      (DATA_VALID_OUT)
`ifdef TX_SYNC_ERR_INJECT_EN
    ,
    .INJECT_SYNC_ERR     (inj_bit)
`endif
  );

  initial USER_CLK = 1'b0;
  always #5 USER_CLK = ~USER_CLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Receiver-side inverse: state is fed from the received (scrambled) bits.
  task automatic descr(input logic [63:0] w, output logic [63:0] d);
    d = '0;
    for (int i = 0; i < 64; i++) begin
      d[i] = w[i] ^ rx_s[38] ^ rx_s[57];
      rx_s = {rx_s[56:0], w[i]};
    end
  endtask

  function automatic logic [63:0] exp_sync();
`ifdef TX_SYNC_ERR_INJECT_EN
    return c_SYNC ^ {63'b0, inj_bit};
`else
    return c_SYNC;
`endif
  endfunction

  // pos: -1 = IDLE edge expected next, 0 = sync, 1 = state word, 2..15 = payload.
  task automatic step(input logic pt, input logic dv, input logic [63:0] d,
                      input logic [1:0] h, output logic took);
    logic        rdy;
    logic [63:0] rec;
    PASSTHROUGH         = pt;
    DATA_VALID          = dv;
    UNSCRAMBLED_DATA_IN = d;
    HEADER_IN           = h;
    #1;
    rdy  = DATA_READY;
    check("ready", 64'(rdy), 64'(pt || (pos >= 2)));
    took = rdy & dv;
    @(posedge USER_CLK);
    #1;
    if (pt) begin
      check("echo_data", SCRAMBLED_DATA_OUT, d);
      check("echo_hdr", 64'(HEADER_OUT), 64'(h));
      check("echo_dvo", 64'(DATA_VALID_OUT), 64'(dv));
      pos = -1;
    end else if (pos < 0) begin
      check("idle_dvo", 64'(DATA_VALID_OUT), 64'(1'b0));
      pos = 0;
    end else begin
      check("dvo", 64'(DATA_VALID_OUT), 64'(1'b1));
      if (pos == 0) begin
        check("sync_word", SCRAMBLED_DATA_OUT, exp_sync());
        check("sync_hdr", 64'(HEADER_OUT), 64'(2'b10));
      end else if (pos == 1) begin
        check("state_hdr", 64'(HEADER_OUT), 64'(2'b10));
        check("state_type", 64'(SCRAMBLED_DATA_OUT[63:58]), 64'(6'b001010));
        if (rx_known) check("state_cont", 64'(SCRAMBLED_DATA_OUT[57:0]), 64'(rx_s));
        rx_s     = SCRAMBLED_DATA_OUT[57:0];
        rx_known = 1'b1;
      end else begin
        descr(SCRAMBLED_DATA_OUT, rec);
        if (dv) begin
          check("payload", rec, d);
          check("payload_hdr", 64'(HEADER_OUT), 64'(h));
        end else begin
          check("idle_payload", rec, 64'h0);
          check("idle_hdr", 64'(HEADER_OUT), 64'(2'b10));
        end
      end
      pos = (pos + 1) % 16;
    end
  endtask

  task automatic do_reset(input int n);
    SYSTEM_RESET = 1'b1;
    PASSTHROUGH  = 1'b0;
    DATA_VALID   = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_ready", 64'(DATA_READY), 64'(1'b0));
      @(posedge USER_CLK);
      #1;
      check("rst_data", SCRAMBLED_DATA_OUT, 64'h0);
      check("rst_hdr", 64'(HEADER_OUT), 64'(2'b00));
      check("rst_dvo", 64'(DATA_VALID_OUT), 64'(1'b0));
    end
    SYSTEM_RESET = 1'b0;
    pos          = -1;
    rx_known     = 1'b0;
  endtask

  initial begin
    logic        took;
    logic [63:0] cnt;
    n_checks = 0;
    n_errors = 0;
    pos      = -1;
    rx_s     = '0;
    rx_known = 1'b0;
    cnt      = 64'h0;
    SYSTEM_RESET        = 1'b1;
    PASSTHROUGH         = 1'b0;
    DATA_VALID          = 1'b0;
    UNSCRAMBLED_DATA_IN = 64'h0;
    HEADER_IN           = 2'b00;
`ifdef TX_SYNC_ERR_INJECT_EN
    inj_bit = 1'b0;
`endif
    @(posedge USER_CLK);
    #1;
    do_reset(2);

    // Continuous counting payload over three meta-frames.
    for (int k = 0; k < 49; k++) begin
      step(1'b0, 1'b1, cnt, 2'b01, took);
      if (k == 2) check("first_state_word", SCRAMBLED_DATA_OUT, c_STATE_SEED);
      if (k == 3) check("first_payload", SCRAMBLED_DATA_OUT, c_FIRST_ZERO);
      if (took) cnt++;
    end
    check("consumed_3_frames", cnt, 64'd42);

    // Three DATA_VALID gaps inside a frame; sync spacing must not move.
    for (int k = 0; k < 18; k++) begin
      step(1'b0, !(k >= 4 && k <= 6), cnt, 2'b01, took);
      if (took) cnt++;
    end

    // Passthrough pulse of five cycles mid-payload, then reframing.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, cnt, 2'b01, took);
      if (took) cnt++;
    end
    for (int k = 0; k < 5; k++)
      step(1'b1, (k != 2), 64'hA5A5_0000_0000_0000 | 64'(k), 2'b11, took);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, cnt, 2'b00, took);
      if (took) cnt++;
    end

    // Reset in the middle of a frame, then a fresh frame from the seed.
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, cnt, 2'b01, took);
      if (k == 2) check("reseed_state_word", SCRAMBLED_DATA_OUT, c_STATE_SEED);
      if (took) cnt++;
    end

`ifdef TX_SYNC_ERR_INJECT_EN
    inj_bit = 1'b1;
    for (int k = 0; k < 16 * 5; k++) begin
      step(1'b0, 1'b1, cnt, 2'b01, took);
      if (took) cnt++;
    end
    inj_bit = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_tx_scrambler
`default_nettype wire
